hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard/stall controller for the 5-stage core. Drives the PC write enable (PCWrite on the PC register), the IF/ID and ID/EX write/flush/bubble controls, and an EX/MEM bubble.
- Sequences load-use stalls, taken-branch flushes and multi-cycle MDU (mul/div) occupancy of EX.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_W, 5, register address width
MDU_LAT, 4, total EX-stage cycles of an MDU instruction; legal range 2..255
CNT_W, 16, performance counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
id_rs  input  REG_W  rs of instruction in ID
id_rt  input  REG_W  rt of instruction in ID
id_uses_rt  input  1  ID instruction reads rt
idex_mem_read  input  1  ID/EX instruction is a load
idex_rt  input  REG_W  destination rt of ID/EX instruction
ex_is_mdu  input  1  level: EX holds an MDU instruction
ex_branch_taken  input  1  EX resolved a taken branch/jump
perf_clr  input  1  synchronous clear of both counters
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID load NOP
idex_write  output  1  ID/EX load enable
idex_bubble  output  1  ID/EX control fields forced to zero
exmem_bubble  output  1  EX/MEM control fields forced to zero
mdu_busy  output  1  FSM in MDU stall
stall_cycles  output  CNT_W  count of cycles with pc_write=0
flush_count  output  CNT_W  count of taken-branch flushes

Behaviour:
- States: RUN, MDU_WAIT, MDU_REL. Reset state RUN; counters reset to 0.
- Control outputs are combinational from state and inputs.
- Default/idle values: pc_write=ifid_write=idex_write=1; ifid_flush=idex_bubble=exmem_bubble=mdu_busy=0.
- While rst=1, outputs are forced to the default/idle values.
- load_use = idex_mem_read & (idex_rt!=0) & ((idex_rt==id_rs) | (id_uses_rt & idex_rt==id_rt)).
- RUN, priority order (highest first):
  - ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1; stay RUN.
  - ex_is_mdu: freeze. pc_write=ifid_write=idex_write=0, exmem_bubble=1, mdu_busy=1. Next state MDU_WAIT if MDU_LAT>=3, else MDU_REL.
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1 (idex_write stays 1 so the bubble is loaded); stay RUN.
- MDU_WAIT:
  - Same freeze outputs as the RUN ex_is_mdu case.
  - ex_branch_taken is ignored.
  - Internal counter sized so total frozen cycles = MDU_LAT-1, counting the entry cycle in RUN; then go to MDU_REL.
- MDU_REL: exactly one release cycle.
  - ex_is_mdu is ignored.
  - Outputs default, except load_use is still evaluated as in RUN.
  - Next state RUN.
- A back-to-back MDU instruction reaching EX after MDU_REL starts a new stall from RUN.
- stall_cycles increments on every non-reset cycle with pc_write=0.
- flush_count increments on every non-reset cycle with ifid_flush=1.
- Both counters saturate at all-ones (no wrap).
- perf_clr has priority over the increment; the count loaded that cycle is 0.
- rst mid-MDU stall: next state RUN, internal counter cleared, counters cleared.

Test Plan:
- Load-use on rs: idex_mem_read=1, idex_rt=8, id_rs=8 for 1 cycle.
  -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_cycles=1.
- Load to $0: same stimulus with idex_rt=0.
  -> no stall. Also id_rt=8 with id_uses_rt=0 -> no stall.
- MDU_LAT=4, ex_is_mdu held 4 cycles:
  - 3 frozen cycles (mdu_busy=1, exmem_bubble=1), then 1 release cycle with defaults.
  - stall_cycles=3.
  - ex_branch_taken pulsed mid-stall is ignored: flush_count stays 0.
- Branch plus load-use in the same RUN cycle:
  -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_count=1.
- Counter saturation:
  - Preload via CNT_W=2 build, 5 stall cycles -> stall_cycles=3.
  - perf_clr during an increment -> 0.
- rst asserted during 2nd MDU frozen cycle:
  -> next cycle outputs default, mdu_busy=0, counters 0.
  - A new ex_is_mdu gives a full 3-cycle freeze.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard/stall controller: load-use stall, branch flush, MDU freeze
module hazard_stall_ctrl #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             ex_is_mdu,
  input  logic             ex_branch_taken,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MDU_WAIT, MDU_REL} state_t;

  // RUN entry cycle plus WAIT_INIT+1 cycles in MDU_WAIT gives MDU_LAT-1 frozen cycles
  localparam logic [7:0] WAIT_INIT = (MDU_LAT >= 3) ? 8'(MDU_LAT - 3) : 8'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_load_use;

  assign w_load_use = idex_mem_read && (idex_rt != '0) &&
                      ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mdu_busy     = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_is_mdu) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            mdu_busy     = 1'b1;
          end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MDU_WAIT: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          mdu_busy     = 1'b1;
        end
        MDU_REL: begin
          if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (!ex_branch_taken && ex_is_mdu) begin
            if (MDU_LAT >= 3) begin
              r_state    <= MDU_WAIT;
              r_wait_cnt <= WAIT_INIT;
            end else begin
              r_state <= MDU_REL;
            end
          end
        end
        MDU_WAIT: begin
          if (r_wait_cnt == 8'd0) begin
            r_state <= MDU_REL;
          end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
        end
        MDU_REL: r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Saturating counters; perf_clr wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_write && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      end
      if (ifid_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
